uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage.
- Consumes the 8N1 line driven by the team's existing UART transmit block, or by the host link.
- Delivers each received byte as a one-cycle strobe to downstream command/config logic.
- Runs at the same bit timing as the transmit side: 10416 clk per bit, so 9600 baud at 100 MHz.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_receiver.sv | 112 +++++++++++
 tb/tb_uart_receiver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state codes
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10416;
    localparam int DATA_BITS            = 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-stage synchronizer for an asynchronous, idle-high input
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Resets to 1 so an idle-high line never looks like a start edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage with mid-bit sampling and break handling
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BITCNT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [BITCNT_W-1:0]  bitcnt;
    logic [DATA_BITS-1:0] sr;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (RxD),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            sr        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt    <= '0;
                        bitcnt <= '0;
                        state  <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        sr     <= {rx_s, sr[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= sr;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it cannot retrigger a frame.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int cyc    = 0;
    int fall_cyc;
    bit both_seen = 1'b0;

    int         vq_cyc[$];
    logic [7:0] vq_data[$];
    int         fq_cyc[$];
    int         exp_cyc[$];
    logic [7:0] exp_data[$];

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RxD      (RxD),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(data);
        end
        if (frame_err) fq_cyc.push_back(cyc);
        if (valid && frame_err) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each good frame yields its byte, valid rising a fixed latency after the falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        fall_cyc = cyc;
        if (stop_bit) begin
            exp_data.push_back(b);
            exp_cyc.push_back(fall_cyc + LAT);
        end
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_frames(input string tag, input int exp_ferr);
        int n;
        int d;
        check({tag, "_count"}, 32'(vq_data.size()), 32'(exp_data.size()));
        n = (vq_data.size() < exp_data.size()) ? vq_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, 32'(vq_data[i]), 32'(exp_data[i]));
            d = vq_cyc[i] - exp_cyc[i];
            check({tag, "_latency_ok"}, 32'(d >= -2 && d <= 2), 32'd1);
        end
        check({tag, "_frame_err"}, 32'(fq_cyc.size()), 32'(exp_ferr));
        vq_cyc.delete();
        vq_data.delete();
        fq_cyc.delete();
        exp_cyc.delete();
        exp_data.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] partial;
        RxD   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic byte
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check_frames("basic", 0);
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_data_held", 32'(data), 32'hA5);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        check_frames("b2b", 0);

        // Glitch rejection
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        check("glitch_busy_seen", 32'(busy), 32'd1);
        repeat (12) @(negedge clk);
        check("glitch_back_idle", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check_frames("glitch", 0);
        check("glitch_data_held", 32'(data), 32'hFF);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("break_busy_low_line", 32'(busy), 32'd1);
        check("break_data_held", 32'(data), 32'hFF);
        RxD = 1'b1;
        repeat (8) @(negedge clk);
        check("break_busy_released", 32'(busy), 32'd0);
        check_frames("ferr", 1);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        check_frames("after_break", 0);

        // Reset during data bit 4 of 0x5A
        partial = 8'h5A;
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = partial[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = partial[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_data", 32'(data), 32'h00);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        RxD   = 1'b1;
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check_frames("midreset_discard", 0);
        send_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        check_frames("midreset_next", 0);

        // Randomized bytes with random idle gaps (zero included)
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            repeat ($urandom_range(0, 24)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_frames("random", 0);

        check("valid_and_frame_err_exclusive", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
